// File: rtl/fxp_round_sched.sv
// fxp_round_sched: two-requester round-robin scheduler feeding a single
// floor/ceil rounding stage into a one-entry result register.
// Optional macro FXP_ROUND_SAT_EN: ceil overflow saturates to the max
// positive integer instead of wrapping (flag is raised either way).
module fxp_round_sched #(
    parameter int WI = 8,
    parameter int WF = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WI+WF-1:0] req0_a,
    input  logic             req0_mode,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WI+WF-1:0] req1_a,
    input  logic             req1_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WI+WF-1:0] res_data,
    output logic             res_oflag,
    output logic             res_id
);
    localparam int W = WI + WF;

    typedef struct packed {
        logic [W-1:0] a;
        logic         mode;
    } op_t;

    logic          prio;
    logic          slot_free;
    logic          both;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          sel;
    op_t           op;
    logic [WI-1:0] int_f;
    logic [WI-1:0] int_r;
    logic          frac_nz;
    logic          ceil_inc;
    logic          ovf;

    // Arbitration: readies only look at valids, slot state and prio.
    always_comb begin
        slot_free  = ~res_valid | res_ready;
        both       = req0_valid & req1_valid;
        grant0     = req0_valid & (~req1_valid | ~prio);
        grant1     = req1_valid & (~req0_valid | prio);
        req0_ready = slot_free & grant0;
        req1_ready = slot_free & grant1;
        accept     = req0_ready | req1_ready;
        sel        = req1_ready;
    end

    // Rounding of the granted operand; the fractional field is always cleared.
    always_comb begin
        op       = sel ? op_t'{a: req1_a, mode: req1_mode}
                       : op_t'{a: req0_a, mode: req0_mode};
        int_f    = op.a[W-1:WF];
        frac_nz  = |op.a[WF-1:0];
        ceil_inc = op.mode & frac_nz;
        ovf      = ceil_inc & (int_f == {1'b0, {(WI-1){1'b1}}});
`ifdef FXP_ROUND_SAT_EN
        int_r    = ovf ? {1'b0, {(WI-1){1'b1}}}
                       : int_f + {{(WI-1){1'b0}}, ceil_inc};
`else
        int_r    = int_f + {{(WI-1){1'b0}}, ceil_inc};
`endif
    end

    // Result register and priority pointer: load on accept, drop valid on
    // a drain without a replacement, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_oflag <= 1'b0;
            res_id    <= 1'b0;
            prio      <= 1'b0;
        end else begin
            if (accept) begin
                res_valid <= 1'b1;
                res_data  <= {int_r, {WF{1'b0}}};
                res_oflag <= ovf;
                res_id    <= sel;
                if (both) prio <= ~sel;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fxp_round_sched.sv
// Bench for fxp_round_sched: behavioural model + per-cycle compare, and
// directed vectors with literal expectations.
module tb_fxp_round_sched;
    localparam int WI = 8;
    localparam int WF = 32;
    localparam int W  = WI + WF;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req1_a = '0;
    logic         req0_mode = 1'b0, req1_mode = 1'b0;
    logic         res_valid, res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_oflag, res_id;

    int errors = 0;
    int checks = 0;

    fxp_round_sched #(.WI(WI), .WF(WF)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_mode(req1_mode),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_oflag(res_oflag), .res_id(res_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rounding with plain integer arithmetic; returns {oflag, data}.
    function automatic logic [W:0] ref_round(input logic [W-1:0] a, input logic mode);
        longint fl, c, maxp;
        logic   of;
        logic [W-1:0] d;
        fl   = longint'($signed(a)) >>> WF;
        maxp = (longint'(1) << (WI - 1)) - 1;
        c    = fl + ((mode && (a[WF-1:0] != '0)) ? 1 : 0);
        of   = (c > maxp);
`ifdef FXP_ROUND_SAT_EN
        if (of) c = maxp;
`endif
        d = '0;
        d[W-1:WF] = WI'(c);
        return {of, d};
    endfunction

    // Model state
    logic         m_valid, m_prio, m_oflag, m_id;
    logic [W-1:0] m_data;

    function automatic logic winner(input logic v0, input logic v1, input logic p);
        if (v0 && v1) return p;
        return v1;
    endfunction

    // Model update on each edge from the inputs present before the edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_prio <= 1'b0; m_oflag <= 1'b0;
            m_id <= 1'b0; m_data <= '0;
        end else begin
            if ((!m_valid || res_ready) && (req0_valid || req1_valid)) begin
                m_valid <= 1'b1;
                m_id    <= winner(req0_valid, req1_valid, m_prio);
                {m_oflag, m_data} <= winner(req0_valid, req1_valid, m_prio)
                    ? ref_round(req1_a, req1_mode) : ref_round(req0_a, req0_mode);
                if (req0_valid && req1_valid)
                    m_prio <= ~winner(req0_valid, req1_valid, m_prio);
            end else if (res_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready0", 64'(req0_ready), 64'((!m_valid || res_ready) && req0_valid
                && winner(req0_valid, req1_valid, m_prio) == 1'b0));
            chk("ready1", 64'(req1_ready), 64'((!m_valid || res_ready) && req1_valid
                && winner(req0_valid, req1_valid, m_prio) == 1'b1));
            chk("res_valid", 64'(res_valid), 64'(m_valid));
            if (m_valid) begin
                chk("res_data", 64'(res_data), 64'(m_data));
                chk("res_oflag", 64'(res_oflag), 64'(m_oflag));
                chk("res_id", 64'(res_id), 64'(m_id));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic which, input logic [W-1:0] a, input logic mode,
                          input logic [W-1:0] exp_d, input logic exp_of, input string name);
        req0_valid = !which; req1_valid = which;
        if (which) begin req1_a = a; req1_mode = mode; end
        else       begin req0_a = a; req0_mode = mode; end
        res_ready = 1'b1;
        step();
        chk({name, "_valid"}, 64'(res_valid), 64'd1);
        chk({name, "_data"}, 64'(res_data), 64'(exp_d));
        chk({name, "_oflag"}, 64'(res_oflag), 64'(exp_of));
        chk({name, "_id"}, 64'(res_id), 64'(which));
    endtask

    logic [W-1:0] held;

    initial begin
        #3;
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_data", 64'(res_data), 64'd0);
        chk("rst_oflag", 64'(res_oflag), 64'd0);
        chk("rst_id", 64'(res_id), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        single(1'b0, 40'h01_80000000, 1'b1, 40'h02_00000000, 1'b0, "ceil_pos");
        single(1'b0, 40'h01_80000000, 1'b0, 40'h01_00000000, 1'b0, "floor_pos");
        single(1'b1, 40'hFE_80000000, 1'b1, 40'hFF_00000000, 1'b0, "ceil_neg");
        single(1'b1, 40'hFE_80000000, 1'b0, 40'hFE_00000000, 1'b0, "floor_neg");
        single(1'b1, 40'h03_00000000, 1'b1, 40'h03_00000000, 1'b0, "ceil_exact");
`ifdef FXP_ROUND_SAT_EN
        single(1'b0, 40'h7F_00000001, 1'b1, 40'h7F_00000000, 1'b1, "ceil_ovf");
`else
        single(1'b0, 40'h7F_00000001, 1'b1, 40'h80_00000000, 1'b1, "ceil_ovf");
`endif
        single(1'b0, 40'h7F_00000001, 1'b0, 40'h7F_00000000, 1'b0, "floor_max");
        single(1'b1, 40'h80_00000001, 1'b1, 40'h81_00000000, 1'b0, "ceil_min");
        single(1'b0, 40'h7F_00000000, 1'b1, 40'h7F_00000000, 1'b0, "ceil_max_exact");

        // Drain without accept
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        step();
        chk("drain_valid", 64'(res_valid), 64'd0);

        // Fairness from reset
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 40'h05_40000000; req0_mode = 1'b1;
        req1_valid = 1'b1; req1_a = 40'h0A_00000000; req1_mode = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_valid", 64'(res_valid), 64'd1);
            chk("fair_id", 64'(res_id), 64'(i % 2));
            chk("fair_data", 64'(res_data), (i % 2) ? 64'h0A_00000000 : 64'h06_00000000);
        end

        // Backpressure: result from requester 1 held for 3 cycles
        res_ready = 1'b0;
        #1;
        held = res_data;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready0", 64'(req0_ready), 64'd0);
            chk("bp_ready1", 64'(req1_ready), 64'd0);
            step();
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_data", 64'(res_data), 64'(held));
            chk("bp_id", 64'(res_id), 64'd1);
        end
        res_ready = 1'b1;
        step();
        chk("bp_next_id", 64'(res_id), 64'd0);
        chk("bp_next_data", 64'(res_data), 64'h06_00000000);

        // Reset mid-cycle with a pending result
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b0; res_ready = 1'b0;
        chk("mid_pre_valid", 64'(res_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(res_valid), 64'd0);
        chk("mid_rst_data", 64'(res_data), 64'd0);
        @(posedge clk); #1;
        chk("mid_rst_hold", 64'(res_valid), 64'd0);
        rst_n = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        step();
        chk("post_rst_id", 64'(res_id), 64'd0);
        chk("post_rst_valid", 64'(res_valid), 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fxp_round_sched.md
FXP_ROUND_SCHED -- requirements
Module: fxp_round_sched

Interface
REQ-001 Parameter WI, default 8: integer bits of the signed fixed-point operand, including the sign bit.
REQ-002 Parameter WF, default 32: fractional bits of the operand.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req0_valid / req1_valid  input  1 each  requester 0/1 has an operand.
REQ-006 req0_ready / req1_ready  output  1 each  operand of requester 0/1 accepted this cycle.
REQ-007 req0_a / req1_a  input  WI+WF each  signed operand, format Int = [WI+WF-1:WF], Frac = [WF-1:0].
REQ-008 req0_mode / req1_mode  input  1 each  0 = floor, 1 = ceil.
REQ-009 res_valid  output  1  result register holds a valid result.
REQ-010 res_ready  input  1  consumer takes the result this cycle.
REQ-011 res_data  output  WI+WF  rounded result, fractional field always zero.
REQ-012 res_oflag  output  1  the integer increment overflowed.
REQ-013 res_id  output  1  index of the requester that owns the result.

Function
REQ-014 Transfer rules: a request transfers when reqN_valid & reqN_ready; a result transfers when res_valid & res_ready.
REQ-015 Output slot: one result register; slot_free = ~res_valid | res_ready.
REQ-016 Grant: reqN_ready = slot_free & grantN.
REQ-017 Single requester: when only one requester is valid, it is granted.
REQ-018 Both valid: the requester equal to the priority pointer prio is granted.
REQ-019 Pointer update: prio moves to the other requester only on a transfer that took place while both requesters were valid.
REQ-020 Ready dependency: readies depend combinationally on reqN_valid, res_valid, res_ready and prio only, never on operand data.
REQ-021 Latency: an operand accepted in cycle N appears on res_* in cycle N+1 with res_valid=1.
REQ-022 Throughput: one result per cycle while res_ready=1.
REQ-023 Hold under backpressure: while res_valid=1 and res_ready=0, res_data, res_oflag and res_id are held and both readies are 0.
REQ-024 Simultaneous drain and accept: a result drain and a new accept in the same cycle load the new result; res_valid stays 1.
REQ-025 Drain without accept: res_valid drops to 0 on the following edge.
REQ-026 Floor: res_data = {Int, WF zeros}; res_oflag = 0.
REQ-027 Ceil, Frac = 0: result equals floor; res_oflag = 0.
REQ-028 Ceil, Frac != 0: the WI-bit signed sum Int+1 wraps modulo 2^WI; res_data = {Int+1, WF zeros}.
REQ-029 Ceil overflow flag: res_oflag = 1 exactly when Int = 2^(WI-1)-1 and Frac != 0.
REQ-030 Handshake state: the control state is the pair {res_valid, prio}; no other handshake state exists.

Reset
REQ-031 On rst_n=0, immediately and regardless of clk: res_valid=0, res_data=0, res_oflag=0, res_id=0, prio=0.
REQ-032 Reset asserted mid-operation discards any held result; nothing is accepted while rst_n=0.
REQ-033 The first grant after reset release follows REQ-017/REQ-018 with prio=0.

Configuration
REQ-034 Macro FXP_ROUND_SAT_EN selects overflow handling.
REQ-035 With FXP_ROUND_SAT_EN defined: a ceil overflow outputs res_data = {0, WI-1 ones, WF zeros} (max positive integer) and res_oflag=1.
REQ-036 Without FXP_ROUND_SAT_EN: a ceil overflow outputs the wrapped value per REQ-028 and res_oflag=1.

Verification
REQ-037 Positive ceil and floor (WI=8, WF=32): req0 a=0x01_80000000 (1.5), mode=1 -> res_data=0x02_00000000, oflag=0. Same a with mode=0 -> 0x01_00000000.
REQ-038 Negative ceil and exact ceil: req1 a=0xFE_80000000 (-1.5), mode=1 -> 0xFF_00000000 (-1), res_id=1. a=0x03_00000000, mode=1 -> 0x03_00000000.
REQ-039 Overflow: a=0x7F_00000001, mode=1 -> 0x80_00000000, oflag=1 without the macro; 0x7F_00000000, oflag=1 with FXP_ROUND_SAT_EN.
REQ-040 Fairness: both requesters valid continuously, res_ready=1 -> res_id sequence 0,1,0,1 from reset, one result per cycle.
REQ-041 Backpressure: hold res_ready=0 for 3 cycles with a pending result -> res_* stable, both readies 0. Raise res_ready -> the next result appears the following cycle.
REQ-042 Reset mid-operation: assert rst_n=0 mid-cycle with res_valid=1 -> res_valid=0 before the next edge. After release, both requesters valid -> requester 0 is granted first.
